// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one 9-bit FIFO write port between NREQ producers.
// Define FIFO_ARB_PKT_LOCK_EN to keep each eop-terminated packet contiguous.
module fifo_wr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [9*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              fifo_write,
  output logic [8:0]        fifo_data_in,
  input  logic              fifo_full
);

  localparam int LW = $clog2(NREQ);
  localparam logic [LW:0] NR = (LW+1)'(NREQ);

  logic [LW-1:0]   last;
  logic [LW-1:0]   win;
  logic [LW:0]     idx;
  logic            found;
  logic            load_ok;
  logic            take;
  logic [NREQ-1:0] elig;
  logic [8:0]      win_word;

  assign load_ok = ~fifo_write | ~fifo_full;

`ifdef FIFO_ARB_PKT_LOCK_EN
  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] owner;
  logic [LW-1:0] owner_nxt;

  // While a packet is open only its owner may be granted.
  assign elig = (state == LOCKED)
              ? (req & (NREQ'(1) << owner))
              : req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    unique case (state)
      IDLE: begin
        if (take && !win_word[8]) begin
          state_nxt = LOCKED;
          owner_nxt = win;
        end
      end
      LOCKED: begin
        if (take && win_word[8]) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
`else
  assign elig = req;
`endif

  // Scan last+1, last+2, ... wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = last;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, last} + (LW+1)'(k);
      if (idx >= NR) begin
        idx = idx - NR;
      end
      if (!found && elig[idx[LW-1:0]]) begin
        found = 1'b1;
        win   = idx[LW-1:0];
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == LW'(i)) begin
        win_word = req_data[9*i +: 9];
      end
    end
  end

  assign take = load_ok & found & ~reset;
  assign gnt  = take ? (NREQ'(1) << win) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_write   <= 1'b0;
      fifo_data_in <= '0;
      last         <= LW'(NREQ-1);
    end else if (load_ok) begin
      fifo_write <= found;
      if (found) begin
        fifo_data_in <= win_word;
        last         <= win;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed steps plus random traffic
// against a queue-based reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [9*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              fifo_write;
  logic [8:0]        fifo_data_in;
  logic              fifo_full;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .fifo_write(fifo_write),
    .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full)
  );

  int tests = 0;
  int errors = 0;

  bit         m_valid;
  logic [8:0] m_data;
  int         m_last;
  bit         m_lock;
  int         m_owner;
  logic [8:0] sb[$];
  logic [8:0] drained[$];
  logic [8:0] pend[NREQ][32];
  int         pn[NREQ];
  int         pi[NREQ];

  logic [NREQ-1:0] o_gnt;
  logic            o_wr;
  logic [8:0]      o_data;
  logic [8:0]      exp4[4];

  task automatic check(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic m_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = NREQ-1;
    m_lock  = 1'b0;
    m_owner = 0;
    sb.delete();
    drained.delete();
    for (int i = 0; i < NREQ; i++) begin
      pn[i] = 0;
      pi[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '1;
    req_data = '0;
    fifo_full = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_wr", fifo_write, 0);
    check("rst_data", fifo_data_in, 0);
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    m_reset();
  endtask

  task automatic push(input int i, input logic [8:0] w);
    pend[i][pn[i]] = w;
    pn[i]++;
  endtask

  // One clock: drive at negedge, check, then advance the model across the edge.
  task automatic cycle(input logic [NREQ-1:0] r,
                       input logic [9*NREQ-1:0] d, input bit f);
    int win;
    int idx;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    req = r;
    req_data = d;
    fifo_full = f;
    #1;
    o_gnt  = gnt;
    o_wr   = fifo_write;
    o_data = fifo_data_in;
    check("fifo_write", o_wr, m_valid);
    if (m_valid) check("fifo_data_in", o_data, m_data);
    if (m_valid && !f) begin
      drained.push_back(o_data);
      if (sb.size() > 0) check("drain_order", o_data, sb.pop_front());
    end
    win = -1;
    eg = '0;
    if (!m_valid || !f) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_last + k) % NREQ;
        if (win < 0 && r[idx] && (!m_lock || idx == m_owner)) win = idx;
      end
    end
    if (win >= 0) eg[win] = 1'b1;
    check("gnt", o_gnt, eg);
    if (!m_valid || !f) begin
      if (win >= 0) begin
        m_data  = d[9*win +: 9];
        m_valid = 1'b1;
        m_last  = win;
        sb.push_back(m_data);
`ifdef FIFO_ARB_PKT_LOCK_EN
        if (!m_lock && !m_data[8]) begin
          m_lock  = 1'b1;
          m_owner = win;
        end else if (m_lock && m_data[8]) begin
          m_lock = 1'b0;
        end
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic run(input int ncyc, input int pfull, input int pdrop);
    logic [NREQ-1:0] r;
    logic [9*NREQ-1:0] d;
    for (int c = 0; c < ncyc; c++) begin
      r = '0;
      d = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (pi[i] < pn[i]) begin
          r[i] = 1'b1;
          d[9*i +: 9] = pend[i][pi[i]];
        end else begin
          d[9*i +: 9] = 9'($urandom);
        end
        if (r[i] && int'($urandom_range(99)) < pdrop) r[i] = 1'b0;
      end
      cycle(r, d, int'($urandom_range(99)) < pfull);
      for (int i = 0; i < NREQ; i++) begin
        if (o_gnt[i]) pi[i]++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    logic [8:0] w;
    reset = 1'b1;
    req = '0;
    req_data = '0;
    fifo_full = 1'b0;
    do_reset();

    cycle(4'b0001, {27'h0, 9'h0A5}, 1'b0);
    check("t1_gnt", o_gnt, 4'b0001);
    cycle(4'b0000, '0, 1'b0);
    check("t1_wr", o_wr, 1);
    check("t1_data", o_data, 9'h0A5);

    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      push(i, 9'(9'h010 + i));
      push(i, 9'(9'h010 + i));
    end
    run(9, 0, 0);
    check("t2_count", drained.size() >= 5, 1);
    for (int j = 0; j < 5; j++) begin
      if (j < drained.size()) check("t2_seq", drained[j], 9'(9'h010 + j % 4));
    end

    do_reset();
    cycle(4'b0001, {27'h0, 9'h055}, 1'b0);
    repeat (5) begin
      cycle(4'b0100, {9'h0, 9'h0C2, 18'h0}, 1'b1);
      check("t3_gnt", o_gnt, 0);
      check("t3_hold", o_data, 9'h055);
      check("t3_wr", o_wr, 1);
    end
    cycle(4'b0100, {9'h0, 9'h0C2, 18'h0}, 1'b0);
    check("t3_gnt_rel", o_gnt, 4'b0100);
    check("t3_drain", o_data, 9'h055);
    cycle(4'b0000, '0, 1'b0);
    check("t3_next", o_data, 9'h0C2);

    do_reset();
    push(0, 9'h001);
    push(0, 9'h002);
    push(0, 9'h103);
    push(1, 9'h1AA);
`ifdef FIFO_ARB_PKT_LOCK_EN
    exp4 = '{9'h001, 9'h002, 9'h103, 9'h1AA};
`else
    exp4 = '{9'h001, 9'h1AA, 9'h002, 9'h103};
`endif
    run(8, 0, 0);
    check("t4_count", drained.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < drained.size()) check("t4_seq", drained[j], exp4[j]);
    end

    do_reset();
    cycle(4'b1000, {9'h0FF, 27'h0}, 1'b0);
    cycle(4'b0000, '0, 1'b1);
    check("t5_slot", o_data, 9'h0FF);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_wr", fifo_write, 0);
    check("t5_data", fifo_data_in, 0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    cycle(4'b1001, {9'h0F3, 18'h0, 9'h0F0}, 1'b0);
    check("t5_gnt", o_gnt, 4'b0001);

    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      left = int'($urandom_range(4, 12));
      for (int j = 0; j < left; j++) begin
        w = 9'($urandom);
        if (j == left - 1) w[8] = 1'b1;
        push(i, w);
      end
    end
    run(300, 30, 10);
    run(60, 0, 0);
    left = 0;
    for (int i = 0; i < NREQ; i++) left += pn[i] - pi[i];
    check("rand_pending", left, 0);
    check("rand_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
